// File: rtl/key_cond.sv
// Key front end for the smart clock: 2-flop sync, per-key debounce, press strobes and an
// optional key-3 auto-repeat strobe (built only when KEY_AUTOREPEAT_EN is defined).
module key_cond #(
  parameter int unsigned DEB_CYCLES  = 200000,
  parameter int unsigned LONG_CYCLES = 10000000,
  parameter int unsigned REP_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw_n,
  output logic [3:0] key_n,
  output logic [3:0] press,
  output logic       mod_rep
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);

  logic [3:0]           sync1_q;
  logic [3:0]           sync2_q;
  logic [3:0][CntW-1:0] cnt_q;
  logic [3:0][CntW-1:0] cnt_d;
  logic [3:0]           key_n_q;
  logic [3:0]           key_n_d;
  logic [3:0]           key_dly_q;
  logic [3:0]           press_q;
  logic [3:0]           press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= key_raw_n;
      sync2_q <= sync1_q;
    end
  end

  // Any sample matching the accepted level throws away the partial count.
  always_comb begin
    key_n_d = key_n_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != key_n_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          key_n_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign press_d = key_dly_q & ~key_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      key_n_q   <= 4'b1111;
      key_dly_q <= 4'b1111;
      press_q   <= 4'b0000;
    end else begin
      cnt_q     <= cnt_d;
      key_n_q   <= key_n_d;
      key_dly_q <= key_n_q;
      press_q   <= press_d;
    end
  end

  assign key_n = key_n_q;
  assign press = press_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned HoldMax = (LONG_CYCLES > REP_CYCLES) ? LONG_CYCLES : REP_CYCLES;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam logic [HoldW-1:0] LongLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLast  = HoldW'(REP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic             mod_rep_q;

  // Release is taken from the next-state level so it beats a coinciding terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      mod_rep_q <= 1'b0;
    end else begin
      mod_rep_q <= 1'b0;
      if (key_n_d[3]) begin
        state_q <= StIdle;
        hold_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (press_d[3]) begin
              state_q <= StHold;
              hold_q  <= '0;
            end
          end
          StHold: begin
            if (hold_q == LongLast) begin
              state_q   <= StRepeat;
              hold_q    <= '0;
              mod_rep_q <= 1'b1;
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
          StRepeat: begin
            if (hold_q == RepLast) begin
              hold_q    <= '0;
              mod_rep_q <= 1'b1;
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            hold_q  <= '0;
          end
        endcase
      end
    end
  end

  assign mod_rep = mod_rep_q;

  strobe_separation_a : assert property (@(posedge clk) disable iff (rst)
    !(press_q[3] && mod_rep_q));
`else
  assign mod_rep = 1'b0;
`endif

endmodule

// File: tb/tb_key_cond.sv
// Directed bench for key_cond with DEB_CYCLES=4, LONG_CYCLES=20, REP_CYCLES=5; expectations
// for mod_rep follow whether KEY_AUTOREPEAT_EN is defined for the build.
module tb_key_cond;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw_n;
  logic [3:0] key_n;
  logic [3:0] press;
  logic       mod_rep;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  key_cond #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20),
    .REP_CYCLES (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw_n(key_raw_n),
    .key_n    (key_n),
    .press    (press),
    .mod_rep  (mod_rep)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    key_raw_n = 4'b1111;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_key;
    logic [3:0] exp_press;
    rst = 1'b1;
    key_raw_n = 4'b0000;
    repeat (3) tick();
    vectors++;
    if (key_n !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_key_n: got %b want 1111", key_n);
    end
    vectors++;
    if (press !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_press: got %b want 0000", press);
    end
    vectors++;
    if (mod_rep !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mod_rep: got %b want 0", mod_rep);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_key   = (i >= 5) ? 4'b0000 : 4'b1111;
      exp_press = (i == 6) ? 4'b1111 : 4'b0000;
      vectors++;
      if (key_n !== exp_key) begin
        miscompares++;
        $display("FAIL post_reset_key_n edge %0d: got %b want %b", i, key_n, exp_key);
      end
      vectors++;
      if (press !== exp_press) begin
        miscompares++;
        $display("FAIL post_reset_press edge %0d: got %b want %b", i, press, exp_press);
      end
      if (i == 8) key_raw_n = 4'b1111;
    end
    settle();
  endtask

  task automatic test_bounce();
    logic pat [8];
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 18; i++) begin
      key_raw_n = {2'b11, (i < 8) ? pat[i] : 1'b1, 1'b1};
      tick();
      vectors++;
      if (key_n !== 4'b1111 || press !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce step %0d: got key_n=%b press=%b want key_n=1111 press=0000",
                 i, key_n, press);
      end
    end
    settle();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_key;
    logic [3:0] exp_press;
    key_raw_n = 4'b1101;
    for (int i = 0; i < 22; i++) begin
      tick();
      exp_key   = (i >= 5 && i < 15) ? 4'b1101 : 4'b1111;
      exp_press = (i == 6) ? 4'b0010 : 4'b0000;
      vectors++;
      if (key_n !== exp_key) begin
        miscompares++;
        $display("FAIL clean_key_n edge %0d: got %b want %b", i, key_n, exp_key);
      end
      vectors++;
      if (press !== exp_press) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: got %b want %b", i, press, exp_press);
      end
      if (i == 9) key_raw_n = 4'b1111;
    end
    settle();
  endtask

  // Holds key 3 from edge 0 and lets go after sampling edge rel_at; mod_rep expected on any
  // edge listed in rep_edges (only when auto-repeat is built).
  task automatic run_mod_hold(input string name, input int rel_at, input int last,
                              input int rep_edges [4]);
    logic [3:0] exp_key;
    logic [3:0] exp_press;
    logic       exp_rep;
    key_raw_n = 4'b0111;
    for (int i = 0; i <= last; i++) begin
      tick();
      exp_key   = (i >= 5 && i < rel_at + 6) ? 4'b0111 : 4'b1111;
      exp_press = (i == 6) ? 4'b1000 : 4'b0000;
      exp_rep   = 1'b0;
      for (int j = 0; j < 4; j++) if (rep_edges[j] == i) exp_rep = AutoRep;
      vectors++;
      if (key_n !== exp_key) begin
        miscompares++;
        $display("FAIL %s_key_n edge %0d: got %b want %b", name, i, key_n, exp_key);
      end
      vectors++;
      if (press !== exp_press) begin
        miscompares++;
        $display("FAIL %s_press edge %0d: got %b want %b", name, i, press, exp_press);
      end
      vectors++;
      if (mod_rep !== exp_rep) begin
        miscompares++;
        $display("FAIL %s_mod_rep edge %0d: got %b want %b", name, i, mod_rep, exp_rep);
      end
      if (i == rel_at) key_raw_n = 4'b1111;
    end
    settle();
  endtask

  task automatic test_autorepeat();
    int reps [4];
    // Press strobe lands on edge 6, so repeats at 6+20, +25, +30, +35.
    reps = '{26, 31, 36, 41};
    run_mod_hold("autorep", 39, 55, reps);
  endtask

  task automatic test_release_wins();
    int reps [4];
    // Accepted release lands on edge 31, the same edge as the second terminal count.
    reps = '{26, -1, -1, -1};
    run_mod_hold("relwins", 25, 65, reps);
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_key;
    logic [3:0] exp_press;
    key_raw_n = 4'b1011;
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (key_n !== 4'b1111 || press !== 4'b0000 || mod_rep !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got key_n=%b press=%b mod_rep=%b want 1111 0000 0",
               key_n, press, mod_rep);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_key   = (i >= 5) ? 4'b1011 : 4'b1111;
      exp_press = (i == 6) ? 4'b0100 : 4'b0000;
      vectors++;
      if (key_n !== exp_key || press !== exp_press) begin
        miscompares++;
        $display("FAIL async_rearm edge %0d: got key_n=%b press=%b want %b %b",
                 i, key_n, press, exp_key, exp_press);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_autorepeat();
    test_release_wins();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
